// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU op codes,
// FSM state encoding and the final iteration index.
package muldiv_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam int ITER_LAST = 31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_msb_flags.sv
// Recovers the 33rd bit of an ADD (carry) or SUB (borrow) from the operand
// and result MSBs, since the shared ALU exposes no carry-out.
module muldiv_msb_flags (
   input  logic a31,
   input  logic b31,
   input  logic res31,
   output logic carry,
   output logic borrow
);

   assign carry  = (a31 & b31) | ((a31 | b31) & ~res31);
   assign borrow = (~a31 & b31) | ((~a31 | b31) & res31);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned 32x32 multiply / 32/32 divide sequencer that borrows
// the EX-stage ALU for its one add or subtract per cycle.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            op_div,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_op,
   input  logic [XLEN-1:0] alu_res
);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   divisor;
   logic [XLEN:0]     rem33;
   logic [XLEN:0]     s33;
   logic              carry;
   logic              borrow;
   logic              ge;
   logic              last_iter;

   assign s33       = {rem33[XLEN-1:0], lo[XLEN-1]};
   assign last_iter = (cnt == CNT_W'(ITER_LAST));
   // A shifted remainder with bit 32 set always exceeds a 32-bit divisor.
   assign ge        = s33[XLEN] | ~borrow;

   muldiv_msb_flags u_flags (
      .a31    (alu_a[XLEN-1]),
      .b31    (alu_b[XLEN-1]),
      .res31  (alu_res[XLEN-1]),
      .carry  (carry),
      .borrow (borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (op_div && (b == '0)) begin
                  state_nxt = S_DONE;
               end else if (op_div) begin
                  state_nxt = S_DIV;
               end else begin
                  state_nxt = S_MUL;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (last_iter) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_AND;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         S_MUL: begin
            alu_a  = hi;
            alu_b  = mcand;
            alu_op = ALU_ADD;
            busy   = 1'b1;
         end
         S_DIV: begin
            alu_a  = s33[XLEN-1:0];
            alu_b  = divisor;
            alu_op = ALU_SUB;
            busy   = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         mcand    <= '0;
         divisor  <= '0;
         rem33    <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt      <= '0;
                  div_zero <= 1'b0;
                  if (op_div && (b == '0)) begin
                     div_zero <= 1'b1;
                     hi       <= a;
                     lo       <= '1;
                  end else if (!op_div) begin
                     hi    <= '0;
                     lo    <= b;
                     mcand <= a;
                  end else begin
                     rem33   <= '0;
                     hi      <= '0;
                     lo      <= a;
                     divisor <= b;
                  end
               end
            end
            S_MUL: begin
               cnt <= cnt + 1'b1;
               // Multiplier bits retire from lo[0] while product bits fill lo[31].
               if (lo[0]) begin
                  hi <= {carry, alu_res[XLEN-1:1]};
                  lo <= {alu_res[0], lo[XLEN-1:1]};
               end else begin
                  hi <= {1'b0, hi[XLEN-1:1]};
                  lo <= {hi[0], lo[XLEN-1:1]};
               end
            end
            S_DIV: begin
               cnt <= cnt + 1'b1;
               if (ge) begin
                  rem33 <= {1'b0, alu_res};
                  hi    <= alu_res;
                  lo    <= {lo[XLEN-2:0], 1'b1};
               end else begin
                  rem33 <= s33;
                  hi    <= s33[XLEN-1:0];
                  lo    <= {lo[XLEN-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
